// File: rtl/distance_calculator_seq.sv
// Sequential redundant-pair distance calculator: dr = ((ow-fw)*dv + d)/st,
// using bit-serial restoring division with valid/ready handshakes and per-cause error flags.
module distance_calculator_seq #(
   parameter int WORD_WIDTH = 8,
   parameter int DIST_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] idx1,
   input  logic [WORD_WIDTH-1:0] idx2,
   input  logic [WORD_WIDTH-1:0] ow,
   input  logic [WORD_WIDTH-1:0] fw,
   input  logic [WORD_WIDTH-1:0] st,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIST_WIDTH-1:0] dr,
   output logic                  dist_valid,
   output logic [3:0]            err
);
   localparam int W  = WORD_WIDTH;
   localparam int W2 = 2 * WORD_WIDTH;
   localparam int CW = $clog2(W2 + 1);

   typedef enum logic [2:0] {IDLE, DIV_FW, MUL, DIV_ST, OUT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    i1_q, i1_d, i2_q, i2_d, ow_q, ow_d, fw_q, fw_d, st_q, st_d;
   logic [W-1:0]    q1_q, q1_d, q2_q, q2_d, r1_q, r1_d, r2_q, r2_d;
   logic [W2-1:0]   n_q, n_d, rs_q, rs_d;
   logic [DIST_WIDTH-1:0] dr_q, dr_d;
   logic [3:0]      err_q, err_d;
   logic            dv_q, dv_d;

   // One restoring-division step per operand; the quotient shifts in where the dividend shifts out.
   logic [W:0]      r1s, r2s, fw_x;
   logic            ge1, ge2;
   logic [W-1:0]    r1n, r2n;
   logic [W2:0]     rss, st_x;
   logic            ges;
   logic [W2-1:0]   rsn, qsn;
   logic [W2-1:0]   wd_x, dvd_x, d_x, nst;
   logic            ovf, sterr;

   always_comb begin
      fw_x  = {1'b0, fw_q};
      r1s   = {r1_q, q1_q[W-1]};
      r2s   = {r2_q, q2_q[W-1]};
      ge1   = (r1s >= fw_x);
      ge2   = (r2s >= fw_x);
      r1n   = ge1 ? W'(r1s - fw_x) : r1s[W-1:0];
      r2n   = ge2 ? W'(r2s - fw_x) : r2s[W-1:0];
      st_x  = {{(W2 + 1 - W){1'b0}}, st_q};
      rss   = {rs_q, n_q[W2-1]};
      ges   = (rss >= st_x);
      rsn   = ges ? W2'(rss - st_x) : rss[W2-1:0];
      qsn   = {n_q[W2-2:0], ges};
      wd_x  = {{W{1'b0}}, W'(ow_q - fw_q)};
      dvd_x = {{W{1'b0}}, W'(q2_q - q1_q)};
      d_x   = {{W{1'b0}}, W'(i2_q - i1_q)};
      nst   = wd_x * dvd_x + d_x;
      ovf   = |(qsn >> DIST_WIDTH);
      sterr = |rsn;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      i1_d = i1_q; i2_d = i2_q; ow_d = ow_q; fw_d = fw_q; st_d = st_q;
      q1_d = q1_q; q2_d = q2_q; r1_d = r1_q; r2_d = r2_q;
      n_d  = n_q;  rs_d = rs_q;
      dr_d = dr_q; err_d = err_q; dv_d = dv_q;
      case (state_q)
         IDLE: if (in_valid) begin
            i1_d = idx1; i2_d = idx2; ow_d = ow; fw_d = fw; st_d = st;
            q1_d = idx1; q2_d = idx2; r1_d = '0; r2_d = '0;
            cnt_d = '0;
            if (fw == '0 || st == '0) begin
               state_d = OUT; err_d = 4'b1000; dr_d = '0; dv_d = 1'b0;
            end else if (idx2 < idx1 || ow < fw) begin
               state_d = OUT; err_d = 4'b0100; dr_d = '0; dv_d = 1'b0;
            end else begin
               state_d = DIV_FW;
            end
         end
         DIV_FW: begin
            q1_d  = {q1_q[W-2:0], ge1};
            q2_d  = {q2_q[W-2:0], ge2};
            r1_d  = r1n;
            r2_d  = r2n;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = MUL;
               cnt_d   = '0;
            end
         end
         MUL: begin
            n_d     = nst;
            rs_d    = '0;
            cnt_d   = '0;
            state_d = DIV_ST;
         end
         DIV_ST: begin
            n_d   = qsn;
            rs_d  = rsn;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W2 - 1)) begin
               state_d = OUT;
               dr_d    = qsn[DIST_WIDTH-1:0];
               err_d   = {2'b00, ovf, sterr};
               dv_d    = ~(ovf | sterr);
            end
         end
         OUT: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         i1_q <= '0; i2_q <= '0; ow_q <= '0; fw_q <= '0; st_q <= '0;
         q1_q <= '0; q2_q <= '0; r1_q <= '0; r2_q <= '0;
         n_q  <= '0; rs_q <= '0;
         dr_q <= '0; err_q <= '0; dv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         i1_q <= i1_d; i2_q <= i2_d; ow_q <= ow_d; fw_q <= fw_d; st_q <= st_d;
         q1_q <= q1_d; q2_q <= q2_d; r1_q <= r1_d; r2_q <= r2_d;
         n_q  <= n_d;  rs_q <= rs_d;
         dr_q <= dr_d; err_q <= err_d; dv_q <= dv_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == OUT);
   assign dr         = dr_q;
   assign err        = err_q;
   assign dist_valid = dv_q;
endmodule

// File: tb/tb_distance_calculator_seq.sv
// Directed bench for distance_calculator_seq: a DIST_WIDTH=3 and a DIST_WIDTH=5 instance
// share stimulus; expected values are hand-computed.
module tb_distance_calculator_seq;
   logic       clk = 1'b0;
   logic       reset, in_valid, out_ready;
   logic [7:0] idx1, idx2, ow, fw, st;
   logic       in_ready, out_valid, dist_valid;
   logic [2:0] dr;
   logic [3:0] err;
   logic       b_in_ready, b_out_valid, b_dist_valid;
   logic [4:0] b_dr;
   logic [3:0] b_err;
   int         total = 0;
   int         bad = 0;
   int         lat;
   logic       seen;

   always #5 clk = ~clk;

   distance_calculator_seq #(.WORD_WIDTH(8), .DIST_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .idx1(idx1), .idx2(idx2), .ow(ow), .fw(fw), .st(st),
      .out_valid(out_valid), .out_ready(out_ready), .dr(dr),
      .dist_valid(dist_valid), .err(err));

   distance_calculator_seq #(.WORD_WIDTH(8), .DIST_WIDTH(5)) dut5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .idx1(idx1), .idx2(idx2), .ow(ow), .fw(fw), .st(st),
      .out_valid(b_out_valid), .out_ready(out_ready), .dr(b_dr),
      .dist_valid(b_dist_valid), .err(b_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Issue one request; lat = rising edges after the acceptance edge until out_valid is seen.
   task automatic req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                      input logic [7:0] f, input logic [7:0] s, output int l);
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) chk("ready_timeout", in_ready, 1);
      idx1 = a; idx2 = b; ow = o; fw = f; st = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      l = 0;
      while (!out_valid && l < 100) begin @(posedge clk); #1; l++; end
   endtask

   task automatic res(input string tag, input logic [2:0] edr, input logic [3:0] eerr,
                      input logic [4:0] edr5, input logic [3:0] eerr5);
      chk({tag, ".ov"}, out_valid, 1);
      chk({tag, ".dr"}, dr, edr);
      chk({tag, ".err"}, err, eerr);
      chk({tag, ".dv"}, dist_valid, ~|eerr);
      chk({tag, ".ov5"}, b_out_valid, 1);
      chk({tag, ".dr5"}, b_dr, edr5);
      chk({tag, ".err5"}, b_err, eerr5);
      chk({tag, ".dv5"}, b_dist_valid, ~|eerr5);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".ov_drop"}, out_valid, 0);
      chk({tag, ".rdy_back"}, in_ready, 1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      idx1 = '0; idx2 = '0; ow = '0; fw = '0; st = '0;
      #12;
      chk("rst.rdy", in_ready, 1);
      chk("rst.ov", out_valid, 0);
      chk("rst.dr", dr, 0);
      chk("rst.err", err, 0);
      chk("rst.dv", dist_valid, 0);
      reset = 1'b0;

      // 7/1: exact, fits in 3 bits
      req(8'd1, 8'd5, 8'd6, 8'd3, 8'd1, lat);
      chk("t1.lat", lat, 25);
      res("t1", 3'd7, 4'b0000, 5'd7, 4'b0000);
      drain("t1");

      // 7/2 = 3 r1
      req(8'd1, 8'd5, 8'd6, 8'd3, 8'd2, lat);
      chk("t2.lat", lat, 25);
      res("t2", 3'd3, 4'b0001, 5'd3, 4'b0001);
      drain("t2");

      // dr_nst = 18: overflows 3 bits, fits 5 bits
      req(8'd0, 8'd8, 8'd8, 8'd3, 8'd1, lat);
      chk("t3.lat", lat, 25);
      res("t3", 3'd2, 4'b0010, 5'd18, 4'b0000);
      drain("t3");

      req(8'd1, 8'd5, 8'd6, 8'd0, 8'd1, lat);
      chk("fw0.lat", lat, 0);
      res("fw0", 3'd0, 4'b1000, 5'd0, 4'b1000);
      drain("fw0");

      req(8'd1, 8'd5, 8'd6, 8'd3, 8'd0, lat);
      chk("st0.lat", lat, 0);
      res("st0", 3'd0, 4'b1000, 5'd0, 4'b1000);
      drain("st0");

      req(8'd5, 8'd1, 8'd6, 8'd3, 8'd1, lat);
      chk("geo.lat", lat, 0);
      res("geo", 3'd0, 4'b0100, 5'd0, 4'b0100);
      drain("geo");

      req(8'd1, 8'd2, 8'd2, 8'd3, 8'd1, lat);
      chk("owfw.lat", lat, 0);
      res("owfw", 3'd0, 4'b0100, 5'd0, 4'b0100);
      drain("owfw");

      // Backpressure: result must hold while inputs churn
      out_ready = 1'b0;
      req(8'd1, 8'd5, 8'd6, 8'd3, 8'd2, lat);
      chk("stall.lat", lat, 25);
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         idx1 = 8'($urandom); idx2 = 8'($urandom); fw = 8'($urandom_range(0, 3));
         @(posedge clk); #1;
         chk("stall.ov", out_valid, 1);
         chk("stall.rdy", in_ready, 0);
         chk("stall.dr", dr, 3);
         chk("stall.err", err, 4'b0001);
      end
      in_valid = 1'b0;
      drain("stall");
      chk("stall.dr_hold", dr, 3);

      // Back-to-back: 11/3 = 3 r2, then 4/1
      req(8'd2, 8'd7, 8'd10, 8'd4, 8'd3, lat);
      chk("b2b1.lat", lat, 25);
      res("b2b1", 3'd3, 4'b0001, 5'd3, 4'b0001);
      drain("b2b1");
      req(8'd3, 8'd4, 8'd5, 8'd2, 8'd1, lat);
      chk("b2b2.lat", lat, 25);
      res("b2b2", 3'd4, 4'b0000, 5'd4, 4'b0000);
      drain("b2b2");

      // Async reset mid-request
      idx1 = 8'd1; idx2 = 8'd5; ow = 8'd6; fw = 8'd3; st = 8'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst.rdy", in_ready, 1);
      chk("arst.ov", out_valid, 0);
      chk("arst.dr", dr, 0);
      chk("arst.err", err, 0);
      chk("arst.dv", dist_valid, 0);
      chk("arst.dr5", b_dr, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen = seen | out_valid; end
      chk("arst.no_ov", seen, 0);

      req(8'd1, 8'd5, 8'd6, 8'd3, 8'd1, lat);
      chk("post.lat", lat, 25);
      res("post", 3'd7, 4'b0000, 5'd7, 4'b0000);
      drain("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
